tmr_fault_monitor: RTL and testbench

Fault-observation stage placed alongside the triple-redundant 8-bit counter, consuming the three replica values and the voted value every cycle. It classifies each cycle as clean, single-replica correctable, or uncorrectable, keeps saturating per-replica error counts, detects persistent (non-transient) replica faults, and raises a one-cycle interrupt pulse when a new sticky condition is first recorded. All outputs are registered; the block never feeds back into the counters.

---
 rtl/tmr_fault_monitor.sv | 139 +++++++++++++
 tb/tb_tmr_fault_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_fault_monitor.sv
// rtl/tmr_fault_monitor.sv - TMR replica fault classifier, error counters, persistence and irq
// Optional persistent-fault detection is enabled by defining TMR_MON_PERSIST_EN.
module tmr_fault_monitor #(
    parameter int WIDTH      = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int PERSIST_TH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     q_1,
    input  logic [WIDTH-1:0]     q_2,
    input  logic [WIDTH-1:0]     q_3,
    input  logic [WIDTH-1:0]     voted_q,
    output logic [2:0]           fault_now,
    output logic [CNT_WIDTH-1:0] err_cnt_1,
    output logic [CNT_WIDTH-1:0] err_cnt_2,
    output logic [CNT_WIDTH-1:0] err_cnt_3,
    output logic [2:0]           perm_fault,
    output logic                 uncorr,
    output logic [CNT_WIDTH-1:0] uncorr_cnt,
    output logic                 irq
);

    // Run counters are 4 bits wide, so the threshold must fit in 1..15.
    if (PERSIST_TH < 1 || PERSIST_TH > 15) begin : g_bad_persist_th
        $error("PERSIST_TH out of range 1..15");
    end

    logic [2:0]                mis;
    logic                      ucr;
    logic [2:0]                fault_now_d, fault_now_q;
    logic [2:0][CNT_WIDTH-1:0] err_cnt_d, err_cnt_q;
    logic                      uncorr_d, uncorr_q;
    logic [CNT_WIDTH-1:0]      uncorr_cnt_d, uncorr_cnt_q;
    logic                      irq_d, irq_q;

    assign mis = {q_3 != voted_q, q_2 != voted_q, q_1 != voted_q};
    assign ucr = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);

`ifdef TMR_MON_PERSIST_EN
    localparam logic [3:0] RUN_TH = 4'(PERSIST_TH);

    logic [2:0][3:0] run_d, run_q;
    logic [2:0]      perm_fault_d, perm_fault_q;

    always_comb begin
        run_d        = run_q;
        perm_fault_d = perm_fault_q;
        if (clear) begin
            run_d        = '0;
            perm_fault_d = 3'b000;
        end else if (enable && !ucr) begin
            for (int i = 0; i < 3; i++) begin
                if (!mis[i]) begin
                    run_d[i] = 4'd0;
                end else if (run_q[i] != RUN_TH) begin
                    run_d[i] = run_q[i] + 4'd1;
                end
                if (mis[i] && run_d[i] == RUN_TH) begin
                    perm_fault_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q        <= '0;
            perm_fault_q <= 3'b000;
        end else begin
            run_q        <= run_d;
            perm_fault_q <= perm_fault_d;
        end
    end

    assign perm_fault = perm_fault_q;
`else
    logic [2:0] perm_fault_d, perm_fault_q;
    assign perm_fault_d = 3'b000;
    assign perm_fault_q = 3'b000;
    assign perm_fault   = 3'b000;
`endif

    always_comb begin
        fault_now_d  = 3'b000;
        err_cnt_d    = err_cnt_q;
        uncorr_d     = uncorr_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clear) begin
            err_cnt_d    = '0;
            uncorr_d     = 1'b0;
            uncorr_cnt_d = '0;
        end else if (enable) begin
            if (ucr) begin
                fault_now_d = 3'b111;
                uncorr_d    = 1'b1;
                if (!(&uncorr_cnt_q)) begin
                    uncorr_cnt_d = uncorr_cnt_q + 1'b1;
                end
            end else begin
                fault_now_d = mis;
                for (int i = 0; i < 3; i++) begin
                    if (mis[i] && !(&err_cnt_q[i])) begin
                        err_cnt_d[i] = err_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
        // Clearing only lowers sticky bits, so it can never raise irq.
        irq_d = (|(perm_fault_d & ~perm_fault_q)) | (uncorr_d & ~uncorr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_now_q  <= 3'b000;
            err_cnt_q    <= '0;
            uncorr_q     <= 1'b0;
            uncorr_cnt_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            fault_now_q  <= fault_now_d;
            err_cnt_q    <= err_cnt_d;
            uncorr_q     <= uncorr_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            irq_q        <= irq_d;
        end
    end

    assign fault_now  = fault_now_q;
    assign err_cnt_1  = err_cnt_q[0];
    assign err_cnt_2  = err_cnt_q[1];
    assign err_cnt_3  = err_cnt_q[2];
    assign uncorr     = uncorr_q;
    assign uncorr_cnt = uncorr_cnt_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb/tb_tmr_fault_monitor.sv - directed self-checking bench for tmr_fault_monitor
module tb_tmr_fault_monitor;

    logic       clk = 1'b0;
    logic       rst, enable, clear;
    logic [7:0] q_1, q_2, q_3, voted_q;
    logic [2:0] fault_now, perm_fault;
    logic [7:0] err_cnt_1, err_cnt_2, err_cnt_3, uncorr_cnt;
    logic       uncorr, irq;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef TMR_MON_PERSIST_EN
    localparam bit PERSIST = 1'b1;
`else
    localparam bit PERSIST = 1'b0;
`endif

    tmr_fault_monitor #(.WIDTH(8), .CNT_WIDTH(8), .PERSIST_TH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .q_1(q_1), .q_2(q_2), .q_3(q_3), .voted_q(voted_q),
        .fault_now(fault_now), .err_cnt_1(err_cnt_1), .err_cnt_2(err_cnt_2),
        .err_cnt_3(err_cnt_3), .perm_fault(perm_fault), .uncorr(uncorr),
        .uncorr_cnt(uncorr_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] v);
        q_1 = a; q_2 = b; q_3 = c; voted_q = v;
    endtask

    task automatic do_clear();
        clear = 1'b1; enable = 1'b0;
        step();
        clear = 1'b0; enable = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        drive(8'h11, 8'h22, 8'h44, 8'h00);
        step(); step();
        n_checks++;
        if ({fault_now, perm_fault, uncorr, irq} !== 8'h00 ||
            {err_cnt_1, err_cnt_2, err_cnt_3, uncorr_cnt} !== 32'h0) begin
            $display("FAIL reset: fault_now=%b perm=%b uncorr=%b irq=%b cnt=%h/%h/%h/%h expected all 0",
                     fault_now, perm_fault, uncorr, irq, err_cnt_1, err_cnt_2, err_cnt_3, uncorr_cnt);
            n_fail++;
        end
        rst = 1'b0;
    endtask

    task automatic test_clean();
        enable = 1'b1;
        drive(8'h05, 8'h05, 8'h05, 8'h05);
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({fault_now, perm_fault, uncorr, irq} !== 8'h00 ||
                {err_cnt_1, err_cnt_2, err_cnt_3, uncorr_cnt} !== 32'h0) begin
                $display("FAIL clean cycle %0d: fault_now=%b perm=%b uncorr=%b irq=%b expected all 0",
                         i, fault_now, perm_fault, uncorr, irq);
                n_fail++;
            end
        end
    endtask

    task automatic test_single();
        do_clear();
        drive(8'h06, 8'h07, 8'h06, 8'h06);
        step();
        n_checks++;
        if (fault_now !== 3'b010 || err_cnt_2 !== 8'd1 || err_cnt_1 !== 8'd0 ||
            err_cnt_3 !== 8'd0 || perm_fault !== 3'b000 || irq !== 1'b0) begin
            $display("FAIL single: fault_now=%b err2=%0d perm=%b irq=%b expected 010 1 000 0",
                     fault_now, err_cnt_2, perm_fault, irq);
            n_fail++;
        end
        drive(8'h06, 8'h06, 8'h06, 8'h06);
        step();
        n_checks++;
        if (fault_now !== 3'b000 || err_cnt_2 !== 8'd1) begin
            $display("FAIL single_recover: fault_now=%b err2=%0d expected 000 1", fault_now, err_cnt_2);
            n_fail++;
        end
    endtask

    task automatic test_persist();
        logic [2:0] exp_perm;
        do_clear();
        drive(8'h06, 8'h06, 8'h09, 8'h06);
        for (int i = 1; i <= 5; i++) begin
            step();
            exp_perm = (PERSIST && i >= 4) ? 3'b100 : 3'b000;
            n_checks++;
            if (perm_fault !== exp_perm || irq !== (PERSIST && i == 4) ||
                fault_now !== 3'b100 || err_cnt_3 !== 8'(i)) begin
                $display("FAIL persist sample %0d: perm=%b irq=%b fault_now=%b err3=%0d expected %b %b 100 %0d",
                         i, perm_fault, irq, fault_now, err_cnt_3, exp_perm, PERSIST && i == 4, i);
                n_fail++;
            end
        end
    endtask

    task automatic test_persist_interrupted();
        do_clear();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) drive(8'h06, 8'h06, 8'h06, 8'h06);
            else        drive(8'h06, 8'h06, 8'h09, 8'h06);
            step();
            n_checks++;
            if (perm_fault !== 3'b000 || irq !== 1'b0) begin
                $display("FAIL persist_break sample %0d: perm=%b irq=%b expected 000 0",
                         i, perm_fault, irq);
                n_fail++;
            end
        end
        n_checks++;
        if (err_cnt_3 !== 8'd6) begin
            $display("FAIL persist_break_cnt: err3=%0d expected 6", err_cnt_3);
            n_fail++;
        end
        // clear mid-run must restart the run counter
        do_clear();
        drive(8'h06, 8'h06, 8'h09, 8'h06);
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (perm_fault !== 3'b000 || irq !== 1'b0 || err_cnt_3 !== 8'd3) begin
            $display("FAIL persist_clear_restart: perm=%b irq=%b err3=%0d expected 000 0 3",
                     perm_fault, irq, err_cnt_3);
            n_fail++;
        end
    endtask

    task automatic test_uncorr();
        do_clear();
        drive(8'h01, 8'h02, 8'h04, 8'h00);
        step();
        n_checks++;
        if (uncorr !== 1'b1 || uncorr_cnt !== 8'd1 || fault_now !== 3'b111 ||
            {err_cnt_1, err_cnt_2, err_cnt_3} !== 24'h0 || irq !== 1'b1 || perm_fault !== 3'b000) begin
            $display("FAIL uncorr: uncorr=%b cnt=%0d fault_now=%b errs=%h/%h/%h irq=%b expected 1 1 111 0/0/0 1",
                     uncorr, uncorr_cnt, fault_now, err_cnt_1, err_cnt_2, err_cnt_3, irq);
            n_fail++;
        end
        step();
        n_checks++;
        if (uncorr !== 1'b1 || uncorr_cnt !== 8'd2 || irq !== 1'b0) begin
            $display("FAIL uncorr_repeat: uncorr=%b cnt=%0d irq=%b expected 1 2 0", uncorr, uncorr_cnt, irq);
            n_fail++;
        end
        drive(8'h00, 8'h00, 8'h00, 8'h00);
        step();
        n_checks++;
        if (uncorr !== 1'b1 || fault_now !== 3'b000 || irq !== 1'b0 || uncorr_cnt !== 8'd2) begin
            $display("FAIL uncorr_sticky: uncorr=%b fault_now=%b irq=%b cnt=%0d expected 1 000 0 2",
                     uncorr, fault_now, irq, uncorr_cnt);
            n_fail++;
        end
    endtask

    task automatic test_saturation_clear();
        do_clear();
        drive(8'h01, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 300; i++) step();
        n_checks++;
        if (err_cnt_1 !== 8'hFF || fault_now !== 3'b001 ||
            perm_fault !== (PERSIST ? 3'b001 : 3'b000)) begin
            $display("FAIL saturate: err1=%h fault_now=%b perm=%b expected ff 001 %b",
                     err_cnt_1, fault_now, perm_fault, PERSIST ? 3'b001 : 3'b000);
            n_fail++;
        end
        clear = 1'b1; enable = 1'b1;
        step();
        n_checks++;
        if ({fault_now, perm_fault, uncorr, irq} !== 8'h00 ||
            {err_cnt_1, err_cnt_2, err_cnt_3, uncorr_cnt} !== 32'h0) begin
            $display("FAIL clear_with_enable: fault_now=%b perm=%b uncorr=%b irq=%b err1=%h expected all 0",
                     fault_now, perm_fault, uncorr, irq, err_cnt_1);
            n_fail++;
        end
        clear = 1'b0;
    endtask

    task automatic test_enable_low();
        do_clear();
        drive(8'h06, 8'h07, 8'h06, 8'h06);
        step();
        enable = 1'b0;
        drive(8'h01, 8'h02, 8'h04, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (fault_now !== 3'b000 || err_cnt_2 !== 8'd1 || uncorr !== 1'b0 ||
                uncorr_cnt !== 8'd0 || irq !== 1'b0 || err_cnt_1 !== 8'd0) begin
                $display("FAIL enable_low cycle %0d: fault_now=%b err2=%0d uncorr=%b cnt=%0d irq=%b expected 000 1 0 0 0",
                         i, fault_now, err_cnt_2, uncorr, uncorr_cnt, irq);
                n_fail++;
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_persist();
        test_persist_interrupted();
        test_uncorr();
        test_saturation_clear();
        test_enable_low();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
